// File: rtl/fetch_pkg.sv
// Shared constants and the prefetch FIFO entry type for the instruction fetch unit.
package fetch_pkg;

    localparam logic [5:0]  OPC_J  = 6'b000010;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} pairs; flush empties it and wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wr_data,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: storage is deliberately not reset; count gates visibility of stale entries.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives the ROM address, queues {pc, inst} for decode.
// Define FETCH_PREDECODE_EN to follow j instructions without waiting for a redirect.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        clr,
    output logic [31:0] a,
    input  logic [31:0] inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    logic [31:0]                 pc;
    logic [31:0]                 pc_plus4;
    logic [31:0]                 next_pc;
    logic                        push;
    logic                        pop;
    logic                        full;
    logic                        empty;
    logic [$clog2(DEPTH+1)-1:0]  count;
    fetch_entry_t                wr_data;
    fetch_entry_t                head;

    assign pop     = out_valid & out_ready;
    // A full FIFO still accepts a fetch when its head leaves in the same cycle.
    assign push    = !redirect & (!full | pop);
    assign wr_data = '{pc: pc, inst: inst};

    always_comb begin
        pc_plus4 = pc + PC_INC;
        next_pc  = pc_plus4;
`ifdef FETCH_PREDECODE_EN
        if (inst[31:26] == OPC_J)
            next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            pc <= RESET_PC;
        else if (redirect)
            pc <= {redirect_pc[31:2], 2'b00};
        else if (push)
            pc <= next_pc;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .push    (push),
        .pop     (pop),
        .flush   (redirect),
        .wr_data (wr_data),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign a         = pc;
    assign out_valid = !empty;
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed table, a predecode stream, then random traffic vs a queue model.
module tb_inst_fetch;

`ifdef FETCH_PREDECODE_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] a;
    logic [31:0] inst;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Test ROM: fixed program at 0x0..0xC, elsewhere an addi-like filler that encodes its address.
    function automatic logic [31:0] rom(input logic [31:0] addr);
        case (addr)
            32'h0:   return 32'h20100010;
            32'h4:   return 32'h10000002;
            32'h8:   return 32'h20100001;
            32'hC:   return 32'h08000001;
            default: return {6'b001000, addr[27:2]};
        endcase
    endfunction

    assign inst = rom(a);

    inst_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .clr         (clr),
        .a           (a),
        .inst        (inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of fetched pairs and the architectural PC.
    logic [31:0] m_pc;
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];

    function automatic logic [31:0] model_next(input logic [31:0] p);
        logic [31:0] w;
        logic [31:0] seq;
        w   = rom(p);
        seq = p + 32'd4;
        if (PRED && w[31:26] == 6'b000010) return {seq[31:28], w[25:0], 2'b00};
        return seq;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        q_pc.delete();
        q_inst.delete();
    endtask

    task automatic model_step(input logic rd, input logic [31:0] rpc, input logic rdy);
        logic pop_m;
        logic push_m;
        pop_m = (q_pc.size() != 0) && rdy;
        if (rd) begin
            q_pc.delete();
            q_inst.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            push_m = (q_pc.size() < DEPTH) || pop_m;
            if (pop_m) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (push_m) begin
                q_pc.push_back(m_pc);
                q_inst.push_back(rom(m_pc));
                m_pc = model_next(m_pc);
            end
        end
    endtask

    task automatic model_compare(input string tag);
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        e_pc   = (q_pc.size() != 0) ? q_pc[0]   : 32'h0;
        e_inst = (q_pc.size() != 0) ? q_inst[0] : 32'h0;
        check({tag, ".a"},         a,                m_pc);
        check({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, q_pc.size() != 0});
        check({tag, ".out_pc"},    out_pc,           e_pc);
        check({tag, ".out_inst"},  out_inst,         e_inst);
    endtask

    task automatic do_reset();
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_a;
    } vec_t;

    vec_t        tbl[14];
    logic [31:0] stream_pc[9];

    initial begin
        logic [31:0] p1;
        logic [31:0] p2;
        p1 = PRED ? 32'h4 : 32'h10;
        p2 = PRED ? 32'h8 : 32'h14;

        // Rows: inputs applied this cycle; expectations are the outputs seen before that edge.
        tbl[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,       32'h0};
        tbl[1]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h20100010, 32'h4};
        tbl[2]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h20100010, 32'h8};
        tbl[3]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h20100010, 32'h8};
        tbl[4]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h20100010, 32'h8};
        tbl[5]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   32'h20100010, 32'h8};
        tbl[6]  = '{1'b1, 32'h6,   1'b1, 1'b1, 32'h4,   32'h10000002, 32'hC};
        tbl[7]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,        32'h4};
        tbl[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   32'h10000002, 32'h8};
        tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   32'h20100001, 32'hC};
        tbl[10] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hC,   32'h08000001, p1};
        tbl[11] = '{1'b1, 32'h100, 1'b1, 1'b1, 32'hC,   32'h08000001, p2};
        tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,        32'h100};
        tbl[13] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h100, rom(32'h100), 32'h104};

        for (int i = 0; i < 9; i++) begin
            if (i < 4)     stream_pc[i] = 32'(i * 4);
            else if (PRED) stream_pc[i] = 32'h4 + 32'(((i - 4) % 3) * 4);
            else           stream_pc[i] = 32'(i * 4);
        end

        // Directed table: stall fill, drain, redirect with pop, full+pop+redirect.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            check($sformatf("tbl[%0d].out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_valid});
            check($sformatf("tbl[%0d].out_pc", i),    out_pc,   tbl[i].e_pc);
            check($sformatf("tbl[%0d].out_inst", i),  out_inst, tbl[i].e_inst);
            check($sformatf("tbl[%0d].a", i),         a,        tbl[i].e_a);
            redirect    = tbl[i].rd;
            redirect_pc = tbl[i].rpc;
            out_ready   = tbl[i].rdy;
            @(negedge clk);
        end

        // Free-running stream with ready held high: shows the j loop when predecode is built in.
        do_reset();
        out_ready = 1'b1;
        check("stream.idle_valid", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("stream[%0d].out_valid", i), {31'b0, out_valid}, 32'h1);
            check($sformatf("stream[%0d].out_pc", i),    out_pc, stream_pc[i]);
            @(negedge clk);
        end

        // Random traffic against the queue model, with an asynchronous clear mid-stream.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic        rd;
            logic [31:0] rpc;
            logic        rdy;
            model_compare($sformatf("rnd[%0d]", cyc));
            if (cyc == 200) begin
                #2 clr = 1'b1;
                #1;
                check("clr.out_valid", {31'b0, out_valid}, 32'h0);
                check("clr.a",         a,                 32'h0);
                check("clr.out_pc",    out_pc,            32'h0);
                clr = 1'b0;
                model_reset();
            end
            rd  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63))
                                              : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            redirect    = rd;
            redirect_pc = rpc;
            out_ready   = rdy;
            model_step(rd, rpc, rdy);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
